// File: rtl/axi_rd_arb_pkg.sv
// rtl/axi_rd_arb_pkg.sv - shared AXI widths, outstanding-depth default, AR FSM encodings
package axi_rd_arb_pkg;

    localparam int AXI_ID_W     = 4;
    localparam int AXI_ADDR_W   = 32;
    localparam int AXI_DATA_W   = 32;
    localparam int AXI_LEN_W    = 8;
    localparam int AXI_SIZE_W   = 3;
    localparam int AXI_BURST_W  = 2;
    localparam int AXI_LOCK_W   = 1;
    localparam int AXI_CACHE_W  = 4;
    localparam int AXI_PROT_W   = 3;
    localparam int AXI_QOS_W    = 4;
    localparam int AXI_REGION_W = 4;
    localparam int AXI_RESP_W   = 2;

    localparam int OST_NUM_DEF  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    // Returns 1 when master 1 should win. With both requesting, the master
    // that did not win last time goes next.
    function automatic logic pick_m1(input logic v0, input logic v1, input logic last_m1);
        if (v0 && v1) begin
            return !last_m1;
        end
        return v1;
    endfunction

endpackage

// File: rtl/axi_rd_arb_sync_fifo.sv
// rtl/axi_rd_arb_sync_fifo.sv - single-clock FIFO used to remember AR grant order
// Ports: clk, rst_n (async, active-low), push/push_data, pop/pop_data (head),
//        empty, full, count (occupancy, FIFO_AW+1 bits).
module sync_fifo #(
    parameter int FIFO_DATA_W = 1,
    parameter int FIFO_DEEP   = 8,
    parameter int FIFO_AW     = $clog2(FIFO_DEEP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [FIFO_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [FIFO_DATA_W-1:0] pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [FIFO_AW:0]       count
);

    logic [FIFO_DATA_W-1:0] mem [FIFO_DEEP];
    logic [FIFO_AW-1:0]     wr_ptr;
    logic [FIFO_AW-1:0]     rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (FIFO_AW+1)'(FIFO_DEEP));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// rtl/axi_rd_arb.sv - two-master AXI read arbiter onto one in-order slave port
// Ports: clk, rst_n (async, active-low); m0_ar*/m0_r* (IFU) and m1_ar*/m1_r* (LSU)
//        master read channels; s_ar*/s_r* shared slave read channel;
//        ost_cnt outstanding bursts; rd_err sticky orphan-beat flag.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int OST_NUM = OST_NUM_DEF,
    parameter int OST_W   = $clog2(OST_NUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_arvalid,
    input  logic [AXI_ID_W-1:0]     m0_arid,
    input  logic [AXI_ADDR_W-1:0]   m0_araddr,
    input  logic [AXI_LEN_W-1:0]    m0_arlen,
    input  logic [AXI_SIZE_W-1:0]   m0_arsize,
    input  logic [AXI_BURST_W-1:0]  m0_arburst,
    input  logic [AXI_LOCK_W-1:0]   m0_arlock,
    input  logic [AXI_CACHE_W-1:0]  m0_arcache,
    input  logic [AXI_PROT_W-1:0]   m0_arprot,
    input  logic [AXI_QOS_W-1:0]    m0_arqos,
    input  logic [AXI_REGION_W-1:0] m0_arregion,
    output logic                    m0_arready,
    output logic                    m0_rvalid,
    output logic [AXI_ID_W-1:0]     m0_rid,
    output logic [AXI_DATA_W-1:0]   m0_rdata,
    output logic [AXI_RESP_W-1:0]   m0_rresp,
    output logic                    m0_rlast,
    input  logic                    m0_rready,

    input  logic                    m1_arvalid,
    input  logic [AXI_ID_W-1:0]     m1_arid,
    input  logic [AXI_ADDR_W-1:0]   m1_araddr,
    input  logic [AXI_LEN_W-1:0]    m1_arlen,
    input  logic [AXI_SIZE_W-1:0]   m1_arsize,
    input  logic [AXI_BURST_W-1:0]  m1_arburst,
    input  logic [AXI_LOCK_W-1:0]   m1_arlock,
    input  logic [AXI_CACHE_W-1:0]  m1_arcache,
    input  logic [AXI_PROT_W-1:0]   m1_arprot,
    input  logic [AXI_QOS_W-1:0]    m1_arqos,
    input  logic [AXI_REGION_W-1:0] m1_arregion,
    output logic                    m1_arready,
    output logic                    m1_rvalid,
    output logic [AXI_ID_W-1:0]     m1_rid,
    output logic [AXI_DATA_W-1:0]   m1_rdata,
    output logic [AXI_RESP_W-1:0]   m1_rresp,
    output logic                    m1_rlast,
    input  logic                    m1_rready,

    output logic                    s_arvalid,
    output logic [AXI_ID_W-1:0]     s_arid,
    output logic [AXI_ADDR_W-1:0]   s_araddr,
    output logic [AXI_LEN_W-1:0]    s_arlen,
    output logic [AXI_SIZE_W-1:0]   s_arsize,
    output logic [AXI_BURST_W-1:0]  s_arburst,
    output logic [AXI_LOCK_W-1:0]   s_arlock,
    output logic [AXI_CACHE_W-1:0]  s_arcache,
    output logic [AXI_PROT_W-1:0]   s_arprot,
    output logic [AXI_QOS_W-1:0]    s_arqos,
    output logic [AXI_REGION_W-1:0] s_arregion,
    input  logic                    s_arready,
    input  logic                    s_rvalid,
    input  logic [AXI_ID_W-1:0]     s_rid,
    input  logic [AXI_DATA_W-1:0]   s_rdata,
    input  logic [AXI_RESP_W-1:0]   s_rresp,
    input  logic                    s_rlast,
    output logic                    s_rready,

    output logic [OST_W:0]          ost_cnt,
    output logic                    rd_err
);

    logic [1:0] state;
    logic       last_m1;
    logic       sel_m1;
    logic       ar_hs;
    logic       fifo_pop;
    logic       fifo_head;
    logic       fifo_empty;
    logic       fifo_full;

    // ---------------- AR arbitration ----------------
    // The grant is a registered state, so s_ar* cannot change under a pending
    // handshake; re-arbitration only happens after passing through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            last_m1 <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_full && (m0_arvalid || m1_arvalid)) begin
                        if (pick_m1(m0_arvalid, m1_arvalid, last_m1)) begin
                            state   <= ST_GNT1;
                            last_m1 <= 1'b1;
                        end else begin
                            state   <= ST_GNT0;
                            last_m1 <= 1'b0;
                        end
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (ar_hs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sel_m1     = (state == ST_GNT1);
    assign s_arvalid  = ((state == ST_GNT0) && m0_arvalid) || ((state == ST_GNT1) && m1_arvalid);
    assign m0_arready = (state == ST_GNT0) && s_arready;
    assign m1_arready = (state == ST_GNT1) && s_arready;
    assign ar_hs      = s_arvalid && s_arready;

    assign s_arid     = sel_m1 ? m1_arid     : m0_arid;
    assign s_araddr   = sel_m1 ? m1_araddr   : m0_araddr;
    assign s_arlen    = sel_m1 ? m1_arlen    : m0_arlen;
    assign s_arsize   = sel_m1 ? m1_arsize   : m0_arsize;
    assign s_arburst  = sel_m1 ? m1_arburst  : m0_arburst;
    assign s_arlock   = sel_m1 ? m1_arlock   : m0_arlock;
    assign s_arcache  = sel_m1 ? m1_arcache  : m0_arcache;
    assign s_arprot   = sel_m1 ? m1_arprot   : m0_arprot;
    assign s_arqos    = sel_m1 ? m1_arqos    : m0_arqos;
    assign s_arregion = sel_m1 ? m1_arregion : m0_arregion;

    // ---------------- ordering FIFO ----------------
    // One bit per outstanding burst: which master owns it. The slave returns
    // bursts in AR order, so the head always names the owner of the current R beat.
    sync_fifo #(
        .FIFO_DATA_W (1),
        .FIFO_DEEP   (OST_NUM),
        .FIFO_AW     (OST_W)
    ) u_order_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_hs),
        .push_data (sel_m1),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (ost_cnt)
    );

    // ---------------- R routing ----------------
    // With nothing outstanding the beat is swallowed (s_rready high) so a
    // misbehaving slave cannot wedge the bus; the event is latched in rd_err.
    assign m0_rvalid = s_rvalid && !fifo_empty && !fifo_head;
    assign m1_rvalid = s_rvalid && !fifo_empty &&  fifo_head;
    assign s_rready  = fifo_empty || (fifo_head ? m1_rready : m0_rready);
    assign fifo_pop  = s_rvalid && s_rready && s_rlast && !fifo_empty;

    assign m0_rid   = s_rid;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err <= 1'b0;
        end else if (s_rvalid && fifo_empty) begin
            rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb/tb_axi_rd_arb.sv - scoreboard bench for axi_rd_arb
module tb_axi_rd_arb;
    import axi_rd_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                    m0_arvalid, m1_arvalid;
    logic [AXI_ID_W-1:0]     m0_arid, m1_arid;
    logic [AXI_ADDR_W-1:0]   m0_araddr, m1_araddr;
    logic [AXI_LEN_W-1:0]    m0_arlen, m1_arlen;
    logic [AXI_SIZE_W-1:0]   ar_size = 3'd2;
    logic [AXI_BURST_W-1:0]  ar_burst = 2'd1;
    logic [AXI_LOCK_W-1:0]   ar_lock = '0;
    logic [AXI_CACHE_W-1:0]  ar_cache = 4'd3;
    logic [AXI_PROT_W-1:0]   ar_prot = '0;
    logic [AXI_QOS_W-1:0]    ar_qos = '0;
    logic [AXI_REGION_W-1:0] ar_region = '0;
    logic                    m0_arready, m1_arready;
    logic                    m0_rvalid, m1_rvalid;
    logic [AXI_ID_W-1:0]     m0_rid, m1_rid;
    logic [AXI_DATA_W-1:0]   m0_rdata, m1_rdata;
    logic [AXI_RESP_W-1:0]   m0_rresp, m1_rresp;
    logic                    m0_rlast, m1_rlast;
    logic                    m0_rready, m1_rready;

    logic                    s_arvalid;
    logic [AXI_ID_W-1:0]     s_arid;
    logic [AXI_ADDR_W-1:0]   s_araddr;
    logic [AXI_LEN_W-1:0]    s_arlen;
    logic [AXI_SIZE_W-1:0]   s_arsize;
    logic [AXI_BURST_W-1:0]  s_arburst;
    logic [AXI_LOCK_W-1:0]   s_arlock;
    logic [AXI_CACHE_W-1:0]  s_arcache;
    logic [AXI_PROT_W-1:0]   s_arprot;
    logic [AXI_QOS_W-1:0]    s_arqos;
    logic [AXI_REGION_W-1:0] s_arregion;
    logic                    s_arready;
    logic                    s_rvalid;
    logic [AXI_ID_W-1:0]     s_rid;
    logic [AXI_DATA_W-1:0]   s_rdata;
    logic [AXI_RESP_W-1:0]   s_rresp;
    logic                    s_rlast;
    logic                    s_rready;
    logic [3:0]              ost_cnt;
    logic                    rd_err;

    axi_rd_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arsize(ar_size), .m0_arburst(ar_burst), .m0_arlock(ar_lock), .m0_arcache(ar_cache),
        .m0_arprot(ar_prot), .m0_arqos(ar_qos), .m0_arregion(ar_region), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arsize(ar_size), .m1_arburst(ar_burst), .m1_arlock(ar_lock), .m1_arcache(ar_cache),
        .m1_arprot(ar_prot), .m1_arqos(ar_qos), .m1_arregion(ar_region), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
        .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rready(s_rready),
        .ost_cnt(ost_cnt), .rd_err(rd_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } r_exp_t;

    ar_exp_t exp_ar[$];
    r_exp_t  exp_r0[$];
    r_exp_t  exp_r1[$];
    ar_exp_t ea;
    r_exp_t  er;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitors (scoreboard pop side) ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) begin
                    fail_now("ar_unexpected");
                end else begin
                    ea = exp_ar.pop_front();
                    check("ar_addr", s_araddr, ea.addr);
                    check("ar_id", s_arid, ea.id);
                    check("ar_len", s_arlen, ea.len);
                    check("ar_size", s_arsize, ar_size);
                end
            end
            if (m0_rvalid && m0_rready) begin
                if (exp_r0.size() == 0) begin
                    fail_now("m0_r_unexpected");
                end else begin
                    er = exp_r0.pop_front();
                    check("m0_rdata", m0_rdata, er.data);
                    check("m0_rid", m0_rid, er.id);
                    check("m0_rlast", m0_rlast, er.last);
                end
            end
            if (m1_rvalid && m1_rready) begin
                if (exp_r1.size() == 0) begin
                    fail_now("m1_r_unexpected");
                end else begin
                    er = exp_r1.pop_front();
                    check("m1_rdata", m1_rdata, er.data);
                    check("m1_rid", m1_rid, er.id);
                    check("m1_rlast", m1_rlast, er.last);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_ar(input int m, input logic v, input logic [31:0] addr,
                            input logic [3:0] id, input logic [7:0] len);
        if (m == 0) begin
            m0_arvalid = v; m0_araddr = addr; m0_arid = id; m0_arlen = len;
        end else begin
            m1_arvalid = v; m1_araddr = addr; m1_arid = id; m1_arlen = len;
        end
    endtask

    task automatic wait_arready(input int m);
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_arready : m1_arready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("arready_timeout");
    endtask

    task automatic ar_issue(input int m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        exp_ar.push_back('{addr, id, len});
        @(posedge clk); #1;
        drive_ar(m, 1'b1, addr, id, len);
        wait_arready(m);
        @(posedge clk); #1;
        drive_ar(m, 1'b0, 32'h0, 4'h0, 8'h0);
    endtask

    task automatic r_drive(input logic [31:0] data, input logic [3:0] id, input logic last);
        bit ok = 0;
        @(posedge clk); #1;
        s_rvalid = 1'b1; s_rdata = data; s_rid = id; s_rlast = last; s_rresp = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_rready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("rready_timeout");
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] data, input logic [3:0] id, input logic last, input int m);
        if (m == 0) exp_r0.push_back('{data, id, last});
        if (m == 1) exp_r1.push_back('{data, id, last});
        r_drive(data, id, last);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ost"}, ost_cnt, 0);
        check({tag, "_rd_err"}, rd_err, 0);
        check({tag, "_s_arvalid"}, s_arvalid, 0);
        check({tag, "_m0_arready"}, m0_arready, 0);
        check({tag, "_m1_arready"}, m1_arready, 0);
        check({tag, "_m0_rvalid"}, m0_rvalid, 0);
        check({tag, "_m1_rvalid"}, m1_rvalid, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_ar(0, 1'b0, 32'h0, 4'h0, 8'h0);
        drive_ar(1, 1'b0, 32'h0, 4'h0, 8'h0);
        s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rdata = '0; s_rid = '0; s_rresp = '0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        #2;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int hs;

        // Single AR from master 0, one-beat response.
        do_reset("rst0");
        exp_ar.push_back('{32'h1000, 4'h1, 8'h0});
        @(posedge clk); #1;
        drive_ar(0, 1'b1, 32'h1000, 4'h1, 8'h0);
        @(negedge clk);
        check("lat_cycle_n_arvalid", s_arvalid, 0);
        @(negedge clk);
        check("lat_cycle_n1_arvalid", s_arvalid, 1);
        check("lat_cycle_n1_araddr", s_araddr, 32'h1000);
        check("lat_cycle_n1_m0_arready", m0_arready, 1);
        check("lat_cycle_n1_m1_arready", m1_arready, 0);
        @(posedge clk); #1;
        drive_ar(0, 1'b0, 32'h0, 4'h0, 8'h0);
        @(negedge clk);
        check("single_ost_1", ost_cnt, 1);
        r_beat(32'hDEADBEEF, 4'h1, 1'b1, 0);
        @(negedge clk);
        check("single_ost_0", ost_cnt, 0);

        // Both masters requesting from reset: alternate 0,1,0,1.
        do_reset("rst1");
        exp_ar.push_back('{32'h2000, 4'h0, 8'h0});
        exp_ar.push_back('{32'h3000, 4'h1, 8'h0});
        exp_ar.push_back('{32'h2000, 4'h0, 8'h0});
        exp_ar.push_back('{32'h3000, 4'h1, 8'h0});
        @(posedge clk); #1;
        drive_ar(0, 1'b1, 32'h2000, 4'h0, 8'h0);
        drive_ar(1, 1'b1, 32'h3000, 4'h1, 8'h0);
        hs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_arvalid && s_arready) begin
                hs++;
                if (hs == 4) break;
            end
        end
        check("alt_handshakes", hs, 4);
        @(posedge clk); #1;
        drive_ar(0, 1'b0, 32'h0, 4'h0, 8'h0);
        drive_ar(1, 1'b0, 32'h0, 4'h0, 8'h0);
        @(negedge clk);
        check("alt_ost_4", ost_cnt, 4);
        r_beat(32'hA0A0_0000, 4'h0, 1'b1, 0);
        r_beat(32'hB1B1_1111, 4'h1, 1'b1, 1);
        r_beat(32'hC2C2_2222, 4'h0, 1'b1, 0);
        r_beat(32'hD3D3_3333, 4'h1, 1'b1, 1);
        @(negedge clk);
        check("alt_ost_0", ost_cnt, 0);

        // GNT1 held with s_arready low while master 0 also requests.
        s_arready = 1'b0;
        exp_ar.push_back('{32'h4000, 4'h2, 8'h0});
        exp_ar.push_back('{32'h5000, 4'h3, 8'h0});
        @(posedge clk); #1;
        drive_ar(1, 1'b1, 32'h4000, 4'h2, 8'h0);
        @(negedge clk);
        @(negedge clk);
        check("hold_gnt1_arvalid", s_arvalid, 1);
        @(posedge clk); #1;
        drive_ar(0, 1'b1, 32'h5000, 4'h3, 8'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_arvalid", s_arvalid, 1);
            check("hold_araddr", s_araddr, 32'h4000);
            check("hold_arid", s_arid, 4'h2);
            check("hold_m0_arready", m0_arready, 0);
        end
        @(posedge clk); #1;
        s_arready = 1'b1;
        wait_arready(1);
        @(posedge clk); #1;
        drive_ar(1, 1'b0, 32'h0, 4'h0, 8'h0);
        wait_arready(0);
        @(posedge clk); #1;
        drive_ar(0, 1'b0, 32'h0, 4'h0, 8'h0);
        @(negedge clk);
        check("hold_ost_2", ost_cnt, 2);
        r_beat(32'h4444_0001, 4'h2, 1'b1, 1);
        r_beat(32'h5555_0002, 4'h3, 1'b1, 0);

        // Fill to OST_NUM, stall, then free one slot.
        do_reset("rst2");
        for (int i = 0; i < 8; i++) begin
            ar_issue(0, 32'h100 * i, 4'(i), 8'h0);
        end
        @(negedge clk);
        check("full_ost_8", ost_cnt, 8);
        exp_ar.push_back('{32'h9000, 4'h9, 8'h0});
        @(posedge clk); #1;
        drive_ar(1, 1'b1, 32'h9000, 4'h9, 8'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_stall_m1_arready", m1_arready, 0);
            check("full_stall_s_arvalid", s_arvalid, 0);
        end
        r_beat(32'h0000_0011, 4'h0, 1'b1, 0);
        @(negedge clk);
        check("full_after_pop_ost_7", ost_cnt, 7);
        wait_arready(1);
        @(posedge clk); #1;
        drive_ar(1, 1'b0, 32'h0, 4'h0, 8'h0);
        @(negedge clk);
        check("full_refill_ost_8", ost_cnt, 8);
        for (int i = 1; i < 8; i++) begin
            r_beat(32'h0000_0010 + i, 4'(i), 1'b1, 0);
        end
        r_beat(32'h9999_0000, 4'h9, 1'b1, 1);
        @(negedge clk);
        check("full_drain_ost_0", ost_cnt, 0);

        // Four-beat burst to master 1 with a one-beat rready stall.
        do_reset("rst3");
        ar_issue(1, 32'hA000, 4'h5, 8'h3);
        r_beat(32'hB000_0000, 4'h5, 1'b0, 1);
        @(negedge clk);
        check("burst_beat1_ost", ost_cnt, 1);
        exp_r1.push_back('{32'hB000_0001, 4'h5, 1'b0});
        @(posedge clk); #1;
        s_rvalid = 1'b1; s_rdata = 32'hB000_0001; s_rid = 4'h5; s_rlast = 1'b0;
        m1_rready = 1'b0;
        @(negedge clk);
        check("burst_stall_s_rready", s_rready, 0);
        check("burst_stall_m1_rvalid", m1_rvalid, 1);
        check("burst_stall_m0_rvalid", m0_rvalid, 0);
        @(posedge clk); #1;
        m1_rready = 1'b1;
        @(negedge clk);
        check("burst_release_s_rready", s_rready, 1);
        @(posedge clk); #1;
        s_rvalid = 1'b0;
        @(negedge clk);
        check("burst_beat2_ost", ost_cnt, 1);
        r_beat(32'hB000_0002, 4'h5, 1'b0, 1);
        @(negedge clk);
        check("burst_beat3_ost", ost_cnt, 1);
        r_beat(32'hB000_0003, 4'h5, 1'b1, 1);
        @(negedge clk);
        check("burst_last_ost", ost_cnt, 0);

        // Orphan R beat, sticky rd_err, then reset with bursts outstanding.
        do_reset("rst4");
        @(posedge clk); #1;
        s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD; s_rid = 4'h0; s_rlast = 1'b1;
        @(negedge clk);
        check("orphan_s_rready", s_rready, 1);
        check("orphan_m0_rvalid", m0_rvalid, 0);
        check("orphan_m1_rvalid", m1_rvalid, 0);
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        check("orphan_rd_err", rd_err, 1);
        check("orphan_ost", ost_cnt, 0);
        repeat (3) @(negedge clk);
        check("orphan_rd_err_sticky", rd_err, 1);
        ar_issue(0, 32'hC000, 4'h1, 8'h1);
        ar_issue(1, 32'hC100, 4'h2, 8'h1);
        ar_issue(0, 32'hC200, 4'h3, 8'h1);
        @(negedge clk);
        check("pre_reset_ost_3", ost_cnt, 3);
        do_reset("rst5");
        @(posedge clk); #1;
        s_rvalid = 1'b1; s_rdata = 32'hC0C0_0000; s_rid = 4'h1; s_rlast = 1'b0;
        @(negedge clk);
        check("post_reset_m0_rvalid", m0_rvalid, 0);
        check("post_reset_m1_rvalid", m1_rvalid, 0);
        @(posedge clk); #1;
        s_rvalid = 1'b0;

        @(negedge clk);
        check("sb_ar_empty", exp_ar.size(), 0);
        check("sb_r0_empty", exp_r0.size(), 0);
        check("sb_r1_empty", exp_r1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
